// File: rtl/seq_pkg.sv
// Shared types and encodings for the instruction sequencer: FSM states,
// ALU operations and the opcode/operand field layout of an instruction word.
package seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_HALTED,
    S_FAULT
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_LDI
  } alu_op_t;

  localparam int OPC_W   = 4;
  localparam int OPR_W   = 4;
  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 4;
  localparam int OPR_MSB = 3;
  localparam int OPR_LSB = 0;

  localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
  localparam logic [OPC_W-1:0] OP_ADD = 4'h1;
  localparam logic [OPC_W-1:0] OP_LDI = 4'h2;
  localparam logic [OPC_W-1:0] OP_SUB = 4'h3;
  localparam logic [OPC_W-1:0] OP_OUT = 4'h4;
  localparam logic [OPC_W-1:0] OP_JMP = 4'h5;
  localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

  // 0x6..0xE are reserved and trap the sequencer.
  function automatic logic opc_legal(input logic [OPC_W-1:0] opc);
    return (opc <= OP_JMP) || (opc == OP_HLT);
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Bundle between the sequencer (master) and its program ROM / host (slave):
// ROM fetch path, start strobe, accumulator, OUT transfer and status flags.
interface instr_sequencer_if #(
  parameter int PC_W   = 16,
  parameter int DATA_W = 8
);
  logic                      start;
  logic [PC_W-1:0]           pc;
  logic [DATA_W-1:0]         word;
  logic                      hlt;
  logic [DATA_W-1:0]         acc;
  logic [DATA_W-1:0]         out_data;
  logic [seq_pkg::OPR_W-1:0] out_port;
  logic                      out_valid;
  logic                      busy;
  logic                      done;
  logic                      fault;
  logic                      carry;
  logic                      zero;

  modport master (
    input  start, word, hlt,
    output pc, acc, out_data, out_port, out_valid, busy, done, fault, carry, zero
  );

  modport slave (
    output start, word, hlt,
    input  pc, acc, out_data, out_port, out_valid, busy, done, fault, carry, zero
  );
endinterface

// File: rtl/seq_alu.sv
// Combinational accumulator ALU: ADD, SUB and LDI with carry/borrow and zero.
module seq_alu
  import seq_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  alu_op_t           i_op,
  input  logic [DATA_W-1:0] i_acc,
  input  logic [DATA_W-1:0] i_imm,
  output logic [DATA_W-1:0] o_result,
  output logic              o_carry,
  output logic              o_zero
);

  // One extra bit holds ADD carry-out, or the borrow of SUB as the sign bit.
  logic [DATA_W:0] w_ext;

  always_comb begin
    w_ext = '0;
    case (i_op)
      ALU_ADD: w_ext = {1'b0, i_acc} + {1'b0, i_imm};
      ALU_SUB: w_ext = {1'b0, i_acc} - {1'b0, i_imm};
      default: w_ext = {1'b0, i_imm};
    endcase
  end

  assign o_result = w_ext[DATA_W-1:0];
  assign o_carry  = w_ext[DATA_W];
  assign o_zero   = (w_ext[DATA_W-1:0] == '0);

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute controller for an 8-bit program ROM: three cycles per
// instruction, accumulator datapath, OUT strobe and an instruction watchdog.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int PC_W      = 16,
  parameter int DATA_W    = 8,
  parameter int MAX_INSTR = 1024
) (
  input  logic              clk,
  input  logic              rst,
  instr_sequencer_if.master io_seq
);

  localparam int CNT_W = (MAX_INSTR < 2) ? 1 : $clog2(MAX_INSTR + 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PC_W-1:0]   r_pc;
  logic [DATA_W-1:0] r_ir;
  logic              r_vld;
  logic [DATA_W-1:0] r_acc;
  logic              r_carry;
  logic              r_zero;
  logic [DATA_W-1:0] r_out_data;
  logic [OPR_W-1:0]  r_out_port;
  logic              r_out_valid;
  logic [CNT_W-1:0]  r_cnt;

  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [OPC_W-1:0]  w_opc;
  logic [OPR_W-1:0]  w_opr;
  logic [DATA_W-1:0] w_imm;
  logic              w_launch;
  logic              w_exec;
  logic              w_wdog_hit;
  logic              w_busy;
  logic              w_done;
  logic              w_fault;
  logic              w_alu_en;
  alu_op_t           w_alu_op;
  logic [DATA_W-1:0] w_alu_res;
  logic              w_alu_carry;
  logic              w_alu_zero;

  assign w_opc      = r_ir[OPC_MSB:OPC_LSB];
  assign w_opr      = r_ir[OPR_MSB:OPR_LSB];
  assign w_imm      = DATA_W'(w_opr);
  assign w_cnt_nxt  = r_cnt + CNT_W'(1);
  // A zero limit turns the watchdog off; the counter then just wraps.
  assign w_wdog_hit = (MAX_INSTR != 0) && (w_cnt_nxt == CNT_W'(MAX_INSTR));

  seq_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .i_op    (w_alu_op),
    .i_acc   (r_acc),
    .i_imm   (w_imm),
    .o_result(w_alu_res),
    .o_carry (w_alu_carry),
    .o_zero  (w_alu_zero)
  );

  always_comb begin
    w_alu_op = ALU_LDI;
    w_alu_en = 1'b0;
    case (w_opc)
      OP_ADD: begin w_alu_op = ALU_ADD; w_alu_en = 1'b1; end
      OP_SUB: begin w_alu_op = ALU_SUB; w_alu_en = 1'b1; end
      OP_LDI: begin w_alu_op = ALU_LDI; w_alu_en = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_exec      = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_fault     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (io_seq.start) begin
          w_launch    = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        w_busy      = 1'b1;
        w_state_nxt = S_DECODE;
      end
      S_DECODE: begin
        w_busy = 1'b1;
        if (!r_vld)                 w_state_nxt = S_HALTED;
        else if (!opc_legal(w_opc)) w_state_nxt = S_FAULT;
        else                        w_state_nxt = S_EXECUTE;
      end
      S_EXECUTE: begin
        w_busy = 1'b1;
        w_exec = 1'b1;
        if (w_wdog_hit)             w_state_nxt = S_FAULT;
        else if (w_opc == OP_HLT)   w_state_nxt = S_HALTED;
        else                        w_state_nxt = S_FETCH;
      end
      S_HALTED: begin
        w_done = 1'b1;
        if (io_seq.start) begin
          w_launch    = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      S_FAULT: begin
        w_fault = 1'b1;
        if (io_seq.start) begin
          w_launch    = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: fetch latches IR, execute commits pc/acc/flags/OUT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= '0;
      r_ir        <= '0;
      r_vld       <= 1'b0;
      r_acc       <= '0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
      r_out_data  <= '0;
      r_out_port  <= '0;
      r_out_valid <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_launch) begin
        r_pc    <= '0;
        r_acc   <= '0;
        r_carry <= 1'b0;
        r_zero  <= 1'b0;
        r_cnt   <= '0;
      end
      if (r_state == S_FETCH) begin
        r_ir  <= io_seq.word;
        r_vld <= io_seq.hlt;
      end
      if (w_exec) begin
        r_cnt <= w_cnt_nxt;
        r_pc  <= (w_opc == OP_JMP) ? PC_W'(w_opr) : r_pc + PC_W'(1);
        if (w_alu_en) begin
          r_acc   <= w_alu_res;
          r_carry <= w_alu_carry;
          r_zero  <= w_alu_zero;
        end
        if (w_opc == OP_OUT) begin
          r_out_data  <= r_acc;
          r_out_port  <= w_opr;
          r_out_valid <= 1'b1;
        end
      end
    end
  end

  assign io_seq.pc        = r_pc;
  assign io_seq.acc       = r_acc;
  assign io_seq.out_data  = r_out_data;
  assign io_seq.out_port  = r_out_port;
  assign io_seq.out_valid = r_out_valid;
  assign io_seq.busy      = w_busy;
  assign io_seq.done      = w_done;
  assign io_seq.fault     = w_fault;
  assign io_seq.carry     = r_carry;
  assign io_seq.zero      = r_zero;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: a program-level reference model checked every
// cycle on the main instance, plus directed literal checks on three instances.
module tb_instr_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic c_hlt;

  instr_sequencer_if #(.PC_W(16), .DATA_W(8)) a_if ();
  instr_sequencer_if #(.PC_W(16), .DATA_W(8)) b_if ();
  instr_sequencer_if #(.PC_W(4),  .DATA_W(8)) c_if ();

  instr_sequencer #(.PC_W(16), .DATA_W(8), .MAX_INSTR(1024)) dut_a (
    .clk(clk), .rst(rst), .io_seq(a_if));
  instr_sequencer #(.PC_W(16), .DATA_W(8), .MAX_INSTR(8)) dut_b (
    .clk(clk), .rst(rst), .io_seq(b_if));
  instr_sequencer #(.PC_W(4), .DATA_W(8), .MAX_INSTR(1024)) dut_c (
    .clk(clk), .rst(rst), .io_seq(c_if));

  // Program ROM for the main instance: words beyond rom_len read as invalid.
  logic [7:0] rom [0:15];
  int         rom_len = 0;

  assign a_if.word = (int'(a_if.pc) < rom_len) ? rom[a_if.pc[3:0]] : 8'h00;
  assign a_if.hlt  = (int'(a_if.pc) < rom_len);
  assign b_if.word = 8'h50;
  assign b_if.hlt  = 1'b1;
  assign c_if.word = 8'h00;
  assign c_if.hlt  = c_hlt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] trace [6] = '{8'd2, 8'd13, 8'd5, 8'd12, 8'd11, 8'd11};

  // Reference model: program-level view (running / halted / faulted) with
  // a cycle counter inside each 3-cycle instruction.
  localparam int A_MAX = 1024;
  logic        m_known = 1'b0;
  logic        m_run, m_done, m_fault, m_ov, m_c, m_z;
  logic [15:0] m_pc;
  logic [7:0]  m_acc, m_od;
  logic [3:0]  m_op;
  int          m_ph, m_cnt;

  function automatic logic [7:0] rom_w(input logic [15:0] p);
    return (int'(p) < rom_len) ? rom[p[3:0]] : 8'h00;
  endfunction

  task automatic model_step();
    logic [7:0] w;
    logic [3:0] opc;
    int         imm;
    int         t;
    if (rst) begin
      m_known = 1'b1; m_run = 1'b0; m_done = 1'b0; m_fault = 1'b0; m_ov = 1'b0;
      m_c = 1'b0; m_z = 1'b0; m_pc = '0; m_acc = '0; m_od = '0; m_op = '0;
      m_ph = 0; m_cnt = 0;
      return;
    end
    m_ov = 1'b0;
    if (!m_run) begin
      if (a_if.start) begin
        m_run = 1'b1; m_done = 1'b0; m_fault = 1'b0; m_ph = 0;
        m_pc = '0; m_acc = '0; m_c = 1'b0; m_z = 1'b0; m_cnt = 0;
      end
      return;
    end
    w   = rom_w(m_pc);
    opc = w[7:4];
    imm = int'(w[3:0]);
    if (m_ph == 0) begin
      m_ph = 1;
    end else if (m_ph == 1) begin
      if (int'(m_pc) >= rom_len) begin
        m_run = 1'b0; m_done = 1'b1;
      end else if (opc >= 4'h6 && opc <= 4'hE) begin
        m_run = 1'b0; m_fault = 1'b1;
      end else begin
        m_ph = 2;
      end
    end else begin
      case (opc)
        4'h1: begin
          t = int'(m_acc) + imm;
          m_c = (t > 255); m_acc = 8'(t % 256); m_z = (m_acc == 8'd0);
        end
        4'h2: begin
          m_acc = 8'(imm); m_c = 1'b0; m_z = (imm == 0);
        end
        4'h3: begin
          m_c = (imm > int'(m_acc));
          m_acc = 8'((int'(m_acc) - imm + 256) % 256); m_z = (m_acc == 8'd0);
        end
        4'h4: begin
          m_od = m_acc; m_op = w[3:0]; m_ov = 1'b1;
        end
        default: ;
      endcase
      m_pc  = (opc == 4'h5) ? 16'(imm) : m_pc + 16'd1;
      m_cnt = m_cnt + 1;
      m_ph  = 0;
      if (m_cnt == A_MAX) begin
        m_run = 1'b0; m_fault = 1'b1;
      end else if (opc == 4'hF) begin
        m_run = 1'b0; m_done = 1'b1;
      end
    end
  endtask

  always @(posedge clk) model_step();

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_all();
    chk("m_busy",      a_if.busy,      m_run);
    chk("m_done",      a_if.done,      m_done);
    chk("m_fault",     a_if.fault,     m_fault);
    chk("m_pc",        a_if.pc,        m_pc);
    chk("m_acc",       a_if.acc,       m_acc);
    chk("m_carry",     a_if.carry,     m_c);
    chk("m_zero",      a_if.zero,      m_z);
    chk("m_out_valid", a_if.out_valid, m_ov);
    chk("m_out_data",  a_if.out_data,  m_od);
    chk("m_out_port",  a_if.out_port,  m_op);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_a();
    a_if.start = 1'b1;
    cyc(1);
    a_if.start = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
  endtask

  initial begin
    rst = 1'b1;
    a_if.start = 1'b0;
    b_if.start = 1'b0;
    c_if.start = 1'b0;
    c_hlt = 1'b1;
    clear_rom();
    rom_len = 0;

    fork
      forever begin
        @(negedge clk);
        if (m_known) cmp_all();
      end
    join_none

    cyc(2);
    rst = 1'b0;
    chk("rst_pc",    a_if.pc,        0);
    chk("rst_acc",   a_if.acc,       0);
    chk("rst_busy",  a_if.busy,      0);
    chk("rst_done",  a_if.done,      0);
    chk("rst_fault", a_if.fault,     0);
    chk("rst_ov",    a_if.out_valid, 0);

    // Scenario 1: the 7-word program
    rom[0] = 8'h22; rom[1] = 8'h2D; rom[2] = 8'h38; rom[3] = 8'h17;
    rom[4] = 8'h31; rom[5] = 8'h07; rom[6] = 8'h43;
    rom_len = 7;
    start_a();
    chk("s1_busy_e0", a_if.busy, 1);
    chk("s1_pc_e0",   a_if.pc,   0);
    for (int i = 0; i < 6; i++) begin
      cyc(3);
      chk("s1_acc_trace", a_if.acc, trace[i]);
    end
    cyc(3);
    chk("s1_out_valid", a_if.out_valid, 1);
    chk("s1_out_data",  a_if.out_data,  8'h0B);
    chk("s1_out_port",  a_if.out_port,  3);
    chk("s1_pc_e21",    a_if.pc,        7);
    cyc(1);
    chk("s1_ov_drop",   a_if.out_valid, 0);
    chk("s1_done_e22",  a_if.done,      0);
    cyc(1);
    chk("s1_done_e23",  a_if.done,      1);
    chk("s1_busy_e23",  a_if.busy,      0);

    // Restart from HALTED clears the accumulator and pc
    start_a();
    chk("s1_rs_acc",  a_if.acc,  0);
    chk("s1_rs_pc",   a_if.pc,   0);
    chk("s1_rs_done", a_if.done, 0);
    cyc(23);
    chk("s1_rs_fin_done", a_if.done, 1);
    chk("s1_rs_fin_acc",  a_if.acc,  8'h0B);

    // Scenario 5: reset during DECODE of instruction 3
    start_a();
    cyc(7);
    rst = 1'b1;
    cyc(1);
    chk("s5_pc",    a_if.pc,        0);
    chk("s5_acc",   a_if.acc,       0);
    chk("s5_od",    a_if.out_data,  0);
    chk("s5_op",    a_if.out_port,  0);
    chk("s5_ov",    a_if.out_valid, 0);
    chk("s5_busy",  a_if.busy,      0);
    chk("s5_done",  a_if.done,      0);
    chk("s5_fault", a_if.fault,     0);
    // start together with rst: rst wins
    a_if.start = 1'b1;
    cyc(1);
    chk("s5_rst_wins", a_if.busy, 0);
    rst = 1'b0;
    a_if.start = 1'b0;
    // start while busy is ignored
    start_a();
    cyc(4);
    a_if.start = 1'b1;
    cyc(1);
    a_if.start = 1'b0;
    chk("s5_busy_start_pc",  a_if.pc,  1);
    chk("s5_busy_start_acc", a_if.acc, 2);
    cyc(18);
    chk("s5_busy_start_done", a_if.done, 1);
    chk("s5_busy_start_acc2", a_if.acc,  8'h0B);

    // Scenario 2: illegal opcode at pc 0
    clear_rom();
    rom[0] = 8'h6A;
    rom_len = 1;
    start_a();
    cyc(2);
    chk("s2_fault", a_if.fault, 1);
    chk("s2_acc",   a_if.acc,   0);
    chk("s2_busy",  a_if.busy,  0);
    cyc(1);
    chk("s2_sticky", a_if.fault, 1);
    start_a();
    chk("s2_clear", a_if.fault, 0);
    chk("s2_refetch_busy", a_if.busy, 1);
    chk("s2_refetch_pc",   a_if.pc,   0);
    cyc(2);
    chk("s2_refault", a_if.fault, 1);

    // Scenario 3: borrow and carry-out
    clear_rom();
    rom[0] = 8'h22; rom[1] = 8'h33; rom[2] = 8'h11;
    rom_len = 3;
    start_a();
    cyc(6);
    chk("s3_sub_acc",   a_if.acc,   8'hFF);
    chk("s3_sub_carry", a_if.carry, 1);
    chk("s3_sub_zero",  a_if.zero,  0);
    cyc(3);
    chk("s3_add_acc",   a_if.acc,   8'h00);
    chk("s3_add_carry", a_if.carry, 1);
    chk("s3_add_zero",  a_if.zero,  1);
    cyc(2);
    chk("s3_done", a_if.done, 1);

    // Scenario 4: JMP 0 loop trips the watchdog after 8 instructions
    b_if.start = 1'b1;
    cyc(1);
    b_if.start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cyc(3);
      chk("s4_pc",    b_if.pc,    0);
      chk("s4_fault", b_if.fault, (i == 8));
    end
    cyc(1);
    chk("s4_sticky", b_if.fault, 1);
    chk("s4_busy",   b_if.busy,  0);

    // Scenario 6: 4-bit pc wraps on NOPs without halting or faulting
    c_if.start = 1'b1;
    cyc(1);
    c_if.start = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      cyc(3);
      chk("s6_pc", c_if.pc, k % 16);
    end
    chk("s6_fault", c_if.fault, 0);
    chk("s6_done",  c_if.done,  0);
    chk("s6_busy",  c_if.busy,  1);
    c_hlt = 1'b0;
    cyc(2);
    chk("s6_halted", c_if.done, 1);
    c_hlt = 1'b1;
    c_if.start = 1'b1;
    cyc(1);
    c_if.start = 1'b0;
    chk("s6_rs_pc",   c_if.pc,   0);
    chk("s6_rs_acc",  c_if.acc,  0);
    chk("s6_rs_busy", c_if.busy, 1);

    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
